// File: rtl/cu_pkg.sv
// Shared control-unit encodings: next-state modes,
// ARM condition codes and status flag bit positions.
package cu_pkg;

  typedef enum logic [2:0] {
    NS_INC     = 3'd0,
    NS_JUMP    = 3'd1,
    NS_DECODE  = 3'd2,
    NS_CJUMP   = 3'd3,
    NS_WAIT    = 3'd4,
    NS_CALL    = 3'd5,
    NS_RET     = 3'd6,
    NS_RESTART = 3'd7
  } ns_sel_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/micro_sequencer_if.sv
// Bundle between the sequencer and its environment:
// IR/flags/ROM fields in, ROM address and status out.
interface micro_sequencer_if #(
  parameter int STATE_W     = 6,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [31:0]        IR_Out;
  logic [3:0]         Flags;
  logic               MFC;
  logic [2:0]         NS_SEL;
  logic [STATE_W-1:0] NS_ADDR;
  logic [STATE_W-1:0] UPC;
  logic               MFA;
  logic               COND_PASS;
  logic [LVL_W-1:0]   STK_LVL;
  logic               STK_ERR;
  logic               TMO;

  modport master (
    output IR_Out, Flags, MFC, NS_SEL, NS_ADDR,
    input  UPC, MFA, COND_PASS, STK_LVL, STK_ERR, TMO
  );

  modport slave (
    input  IR_Out, Flags, MFC, NS_SEL, NS_ADDR,
    output UPC, MFA, COND_PASS, STK_LVL, STK_ERR, TMO
  );

endinterface

// File: rtl/cond_eval.sv
// ARM condition-code evaluator, purely combinational.
// Shared between the sequencer and the datapath.
module cond_eval
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: computes the next control-ROM
// address with call stack, condition test and MFC timeout.
module micro_sequencer
  import cu_pkg::*;
#(
  parameter int STATE_W     = 6,
  parameter int STACK_DEPTH = 4,
  parameter int MFC_TIMEOUT = 15,
  parameter int FETCH_ADDR  = 0,
  parameter int DECODE_BASE = 16,
  parameter int ABORT_ADDR  = 63
) (
  input logic CLK,
  input logic CLR,
  micro_sequencer_if.slave bus
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W =
    (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(MFC_TIMEOUT);

  localparam logic [STATE_W-1:0] FETCH =
    STATE_W'(FETCH_ADDR);
  localparam logic [STATE_W-1:0] ABORT =
    STATE_W'(ABORT_ADDR);
  localparam logic [STATE_W-1:0] DBASE =
    STATE_W'(DECODE_BASE);
  localparam logic [LVL_W-1:0] FULL =
    LVL_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MFC_TIMEOUT - 1);

  logic [STATE_W-1:0] upc_q, upc_d, upc_inc;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;
  logic               push;
  logic               pass;
  logic [IDX_W-1:0]   widx, ridx;
  logic [3:0]         dec_off;
  logic [STATE_W-1:0] stk_q [STACK_DEPTH];

  cond_eval u_cond (
    .cond  (bus.IR_Out[31:28]),
    .flags (bus.Flags),
    .pass  (pass)
  );

  assign upc_inc = upc_q + 1'b1;
  assign widx    = lvl_q[IDX_W-1:0];
  assign ridx    = widx - 1'b1;
  assign dec_off = {bus.IR_Out[27:25], bus.IR_Out[20]};

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      upc_q <= FETCH;
      lvl_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end

  // Entries above lvl_q are dead, so the array needs no reset.
  always_ff @(posedge CLK) begin
    if (CLR && push) begin
      stk_q[widx] <= upc_inc;
    end
  end

  always_comb begin
    upc_d = upc_q;
    lvl_d = lvl_q;
    cnt_d = '0;
    err_d = err_q;
    tmo_d = tmo_q;
    push  = 1'b0;
    unique case (bus.NS_SEL)
      NS_INC:    upc_d = upc_inc;
      NS_JUMP:   upc_d = bus.NS_ADDR;
      NS_DECODE: upc_d = DBASE + STATE_W'(dec_off);
      NS_CJUMP:  upc_d = pass ? bus.NS_ADDR : upc_inc;
      NS_WAIT: begin
        if (bus.MFC) begin
          upc_d = upc_inc;
        end else if (cnt_q == CNT_LAST) begin
          upc_d = ABORT;
          tmo_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NS_CALL: begin
        if (lvl_q == FULL) begin
          upc_d = ABORT;
          err_d = 1'b1;
        end else begin
          upc_d = bus.NS_ADDR;
          lvl_d = lvl_q + 1'b1;
          push  = 1'b1;
        end
      end
      NS_RET: begin
        if (lvl_q == '0) begin
          upc_d = ABORT;
          err_d = 1'b1;
        end else begin
          upc_d = stk_q[ridx];
          lvl_d = lvl_q - 1'b1;
        end
      end
      NS_RESTART: begin
        upc_d = FETCH;
        lvl_d = '0;
        err_d = 1'b0;
        tmo_d = 1'b0;
      end
    endcase
  end

  assign bus.UPC       = upc_q;
  assign bus.MFA       = (bus.NS_SEL == NS_WAIT);
  assign bus.COND_PASS = pass;
  assign bus.STK_LVL   = lvl_q;
  assign bus.STK_ERR   = err_q;
  assign bus.TMO       = tmo_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomised and directed bench for micro_sequencer with
// a queue-based reference model of the sequencing rules.
module tb_micro_sequencer;

  localparam int SW    = 6;
  localparam int DEPTH = 4;
  localparam int TOUT  = 15;
  localparam int ABRT  = 63;
  localparam int MOD   = 64;

  logic CLK, CLR;
  int n_chk, n_fail;

  int m_upc;
  int m_stk[$];
  bit m_err, m_tmo;
  int m_miss;

  micro_sequencer_if #(.STATE_W(SW), .STACK_DEPTH(DEPTH)) bus ();

  micro_sequencer #(
    .STATE_W(SW), .STACK_DEPTH(DEPTH), .MFC_TIMEOUT(TOUT),
    .FETCH_ADDR(0), .DECODE_BASE(16), .ABORT_ADDR(ABRT)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ARM conditions come in complementary pairs; odd codes negate.
  function automatic bit ref_cond(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  task automatic model_step(input bit clr, input int sel,
                            input int addr, input bit mfc,
                            input logic [31:0] ir,
                            input logic [3:0] fl);
    int inc;
    inc = (m_upc + 1) % MOD;
    if (!clr) begin
      m_upc = 0; m_stk.delete(); m_err = 0; m_tmo = 0; m_miss = 0;
      return;
    end
    if (sel != 4) m_miss = 0;
    case (sel)
      0: m_upc = inc;
      1: m_upc = addr;
      2: m_upc = (16 + 2 * int'(ir[27:25]) + int'(ir[20])) % MOD;
      3: m_upc = ref_cond(ir[31:28], fl) ? addr : inc;
      4: begin
        if (mfc) begin
          m_upc = inc; m_miss = 0;
        end else if (m_miss + 1 == TOUT) begin
          m_upc = ABRT; m_tmo = 1; m_miss = 0;
        end else begin
          m_miss++;
        end
      end
      5: begin
        if (m_stk.size() == DEPTH) begin
          m_upc = ABRT; m_err = 1;
        end else begin
          m_stk.push_back(inc); m_upc = addr;
        end
      end
      6: begin
        if (m_stk.size() == 0) begin
          m_upc = ABRT; m_err = 1;
        end else begin
          m_upc = m_stk.pop_back();
        end
      end
      default: begin
        m_upc = 0; m_stk.delete(); m_err = 0; m_tmo = 0;
      end
    endcase
  endtask

  task automatic cyc(input bit clr, input int sel,
                     input int addr, input bit mfc);
    CLR = clr;
    bus.NS_SEL = 3'(sel);
    bus.NS_ADDR = 6'(addr);
    bus.MFC = mfc;
    @(posedge CLK);
    model_step(clr, sel, addr, mfc, bus.IR_Out, bus.Flags);
    #1;
  endtask

  task automatic test_reset;
    cyc(0, 1, 5, 0);
    cyc(0, 1, 5, 0);
    n_chk++;
    if ({bus.UPC, bus.STK_LVL, bus.STK_ERR, bus.TMO} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state got upc=%0d lvl=%0d err=%b tmo=%b exp all 0",
               bus.UPC, bus.STK_LVL, bus.STK_ERR, bus.TMO);
    end
    cyc(1, 1, 8, 0);
    bus.NS_SEL = 3'd4;
    #1;
    n_chk++;
    if (bus.MFA !== 1'b1) begin
      n_fail++; $display("FAIL wait_mfa got %b exp 1", bus.MFA);
    end
    cyc(1, 4, 0, 0);
    cyc(1, 4, 0, 0);
    cyc(0, 4, 0, 0);
    n_chk++;
    if (bus.UPC !== 6'd0 || bus.MFA !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_wait got upc=%0d mfa=%b exp 0 1", bus.UPC, bus.MFA);
    end
    for (int i = 0; i < 13; i++) cyc(1, 4, 0, 0);
    n_chk++;
    if (bus.UPC !== 6'd0 || bus.TMO !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_cnt_cleared got upc=%0d tmo=%b exp 0 0", bus.UPC, bus.TMO);
    end
    cyc(1, 0, 0, 0);
    n_chk++;
    if (bus.MFA !== 1'b0 || bus.UPC !== 6'd1) begin
      n_fail++;
      $display("FAIL mfa_drop got mfa=%b upc=%0d exp 0 1", bus.MFA, bus.UPC);
    end
  endtask

  task automatic test_decode;
    bus.IR_Out = 32'hE2010000;
    cyc(1, 2, 0, 0);
    n_chk++;
    if (bus.UPC !== 6'd18) begin
      n_fail++; $display("FAIL decode_dp got %0d exp 18", bus.UPC);
    end
    bus.IR_Out = 32'hE5910000;
    cyc(1, 2, 0, 0);
    n_chk++;
    if (bus.UPC !== 6'd21) begin
      n_fail++; $display("FAIL decode_ldr got %0d exp 21", bus.UPC);
    end
  endtask

  task automatic test_condition;
    bus.IR_Out = 32'h0000_0000;
    bus.Flags = 4'b0100;
    cyc(1, 1, 10, 0);
    cyc(1, 3, 40, 0);
    n_chk++;
    if (bus.UPC !== 6'd40) begin
      n_fail++; $display("FAIL cjump_eq_taken got %0d exp 40", bus.UPC);
    end
    bus.Flags = 4'b0000;
    cyc(1, 1, 10, 0);
    cyc(1, 3, 40, 0);
    n_chk++;
    if (bus.UPC !== 6'd11) begin
      n_fail++; $display("FAIL cjump_eq_not got %0d exp 11", bus.UPC);
    end
    bus.IR_Out = 32'hF000_0000;
    bus.Flags = 4'($urandom_range(0, 15));
    cyc(1, 1, 10, 0);
    cyc(1, 3, 40, 0);
    n_chk++;
    if (bus.UPC !== 6'd11) begin
      n_fail++; $display("FAIL cjump_nv got %0d exp 11", bus.UPC);
    end
    bus.IR_Out = 32'hC000_0000;
    bus.Flags = 4'b1001;
    cyc(1, 1, 10, 0);
    cyc(1, 3, 40, 0);
    n_chk++;
    if (bus.UPC !== 6'd40) begin
      n_fail++; $display("FAIL cjump_gt got %0d exp 40", bus.UPC);
    end
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        bus.IR_Out = {4'(c), 28'h0};
        bus.Flags = 4'(f);
        #1;
        n_chk++;
        if (bus.COND_PASS !== ref_cond(4'(c), 4'(f))) begin
          n_fail++;
          $display("FAIL cond_pass c=%h f=%b got %b exp %b",
                   c, f, bus.COND_PASS, ref_cond(4'(c), 4'(f)));
        end
      end
    end
  endtask

  task automatic test_handshake;
    cyc(1, 1, 8, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4, 0, 0);
      n_chk++;
      if (bus.UPC !== 6'd8 || bus.MFA !== 1'b1) begin
        n_fail++;
        $display("FAIL wait_hold got upc=%0d mfa=%b exp 8 1", bus.UPC, bus.MFA);
      end
    end
    cyc(1, 4, 0, 1);
    n_chk++;
    if (bus.UPC !== 6'd9) begin
      n_fail++; $display("FAIL wait_done got %0d exp 9", bus.UPC);
    end
    cyc(1, 1, 8, 0);
    for (int i = 0; i < 14; i++) cyc(1, 4, 0, 0);
    cyc(1, 4, 0, 1);
    n_chk++;
    if (bus.UPC !== 6'd9 || bus.TMO !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_last_mfc got upc=%0d tmo=%b exp 9 0", bus.UPC, bus.TMO);
    end
    cyc(1, 1, 8, 0);
    for (int i = 0; i < 14; i++) cyc(1, 4, 0, 0);
    n_chk++;
    if (bus.UPC !== 6'd8 || bus.TMO !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_pre_tmo got upc=%0d tmo=%b exp 8 0", bus.UPC, bus.TMO);
    end
    cyc(1, 4, 0, 0);
    n_chk++;
    if (bus.UPC !== 6'd63 || bus.TMO !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_timeout got upc=%0d tmo=%b exp 63 1", bus.UPC, bus.TMO);
    end
  endtask

  task automatic test_stack;
    int tgt[5] = '{11, 21, 31, 40, 50};
    int ret[4] = '{32, 22, 12, 3};
    cyc(1, 7, 0, 0);
    cyc(1, 1, 2, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 5, tgt[i], 0);
      n_chk++;
      if (bus.UPC !== 6'(tgt[i]) || bus.STK_LVL !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL call_%0d got upc=%0d lvl=%0d exp %0d %0d",
                 i, bus.UPC, bus.STK_LVL, tgt[i], i + 1);
      end
    end
    cyc(1, 5, tgt[4], 0);
    n_chk++;
    if (bus.UPC !== 6'd63 || bus.STK_ERR !== 1'b1 || bus.STK_LVL !== 3'd4) begin
      n_fail++;
      $display("FAIL call_overflow got upc=%0d err=%b lvl=%0d exp 63 1 4",
               bus.UPC, bus.STK_ERR, bus.STK_LVL);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 6, 0, 0);
      n_chk++;
      if (bus.UPC !== 6'(ret[i]) || bus.STK_LVL !== 3'(3 - i)) begin
        n_fail++;
        $display("FAIL ret_%0d got upc=%0d lvl=%0d exp %0d %0d",
                 i, bus.UPC, bus.STK_LVL, ret[i], 3 - i);
      end
    end
    cyc(1, 6, 0, 0);
    n_chk++;
    if (bus.UPC !== 6'd63 || bus.STK_ERR !== 1'b1 || bus.STK_LVL !== 3'd0) begin
      n_fail++;
      $display("FAIL ret_underflow got upc=%0d err=%b lvl=%0d exp 63 1 0",
               bus.UPC, bus.STK_ERR, bus.STK_LVL);
    end
  endtask

  task automatic test_recovery;
    cyc(1, 1, 8, 0);
    for (int i = 0; i < 15; i++) cyc(1, 4, 0, 0);
    cyc(1, 5, 5, 0);
    n_chk++;
    if (bus.TMO !== 1'b1 || bus.STK_ERR !== 1'b1 || bus.STK_LVL !== 3'd1) begin
      n_fail++;
      $display("FAIL pre_restart got tmo=%b err=%b lvl=%0d exp 1 1 1",
               bus.TMO, bus.STK_ERR, bus.STK_LVL);
    end
    cyc(1, 7, 0, 0);
    n_chk++;
    if ({bus.UPC, bus.STK_LVL, bus.STK_ERR, bus.TMO} !== 11'd0) begin
      n_fail++;
      $display("FAIL restart got upc=%0d lvl=%0d err=%b tmo=%b exp all 0",
               bus.UPC, bus.STK_LVL, bus.STK_ERR, bus.TMO);
    end
    cyc(1, 1, 63, 0);
    cyc(1, 0, 0, 0);
    n_chk++;
    if (bus.UPC !== 6'd0) begin
      n_fail++; $display("FAIL inc_wrap got %0d exp 0", bus.UPC);
    end
  endtask

  task automatic test_random;
    bit clr, mfc;
    int sel, addr;
    for (int i = 0; i < 600; i++) begin
      clr = ($urandom_range(0, 99) >= 2);
      sel = $urandom_range(0, 7);
      if (sel == 7 && $urandom_range(0, 3) != 0) sel = 5;
      addr = $urandom_range(0, 63);
      mfc = ($urandom_range(0, 3) == 0);
      if (i % 100 >= 78 && i % 100 < 96) begin
        sel = 4; mfc = (i % 200 == 95); clr = 1;
      end
      bus.IR_Out = $urandom;
      bus.Flags = 4'($urandom_range(0, 15));
      bus.NS_SEL = 3'(sel);
      #1;
      n_chk++;
      if (bus.MFA !== (sel == 4) ||
          bus.COND_PASS !== ref_cond(bus.IR_Out[31:28], bus.Flags)) begin
        n_fail++;
        $display("FAIL rnd_comb i=%0d got mfa=%b pass=%b", i, bus.MFA, bus.COND_PASS);
      end
      cyc(clr, sel, addr, mfc);
      n_chk++;
      if (bus.UPC !== 6'(m_upc) || bus.STK_LVL !== 3'(m_stk.size()) ||
          bus.STK_ERR !== m_err || bus.TMO !== m_tmo) begin
        n_fail++;
        $display("FAIL rnd_state i=%0d sel=%0d got upc=%0d lvl=%0d err=%b tmo=%b exp %0d %0d %b %b",
                 i, sel, bus.UPC, bus.STK_LVL, bus.STK_ERR, bus.TMO,
                 m_upc, m_stk.size(), m_err, m_tmo);
      end
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    m_upc = 0; m_err = 0; m_tmo = 0; m_miss = 0;
    CLR = 1'b0;
    bus.IR_Out = '0; bus.Flags = '0; bus.MFC = 1'b0;
    bus.NS_SEL = '0; bus.NS_ADDR = '0;
    test_reset();
    test_decode();
    test_condition();
    test_handshake();
    test_stack();
    test_recovery();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
